countdown_timer: RTL
====================

# countdown_timer

Memory-mapped programmable countdown timer peripheral with one-shot and periodic modes and a level interrupt output. It sits on the same 8-bit-address / 32-bit-data peripheral bus as the free-running system timer. The system timer only counts up and is read by software; this block takes a software-written deadline and signals expiry back to the core. A prescaler derives a fixed tick from the system clock, and a 32-bit down-counter decrements once per tick.

## Interface
- `CLK_HZ`, default `` `CLK_FREQ ``: system clock frequency in Hz.
- `TICK_HZ`, default 1000000: tick rate. `PRE_LIMIT = CLK_HZ/TICK_HZ - 1`. `CLK_HZ >= TICK_HZ` is required.
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `address`, input, 8: register byte offset.
- `write_data`, input, 32: write data.
- `read_data`, output, 32: combinational read mux. Unmapped offsets read 0.
- `we`, input, 1: write strobe, one cycle per access.
- `re`, input, 1: read strobe. Reads have no side effects, so `re` is unused.
- `irq`, output, 1: level interrupt, equal to `EXPIRED & IRQ_EN`. Reset value 0.

## Operation
- Registers; all reset to 0:
  - 0x00 `LOAD` (R/W): reload value.
  - 0x04 `COUNT` (R/W): current count. A write sets the count and clears the prescaler.
  - 0x08 `CTRL` (R/W): bit0 `EN`, bit1 `PERIODIC`, bit2 `IRQ_EN`. Upper bits read 0.
  - 0x0C `STATUS`: bit0 `EXPIRED`, write-1-to-clear.
  - 0x10 `EXP_CNT` (R): expiry count. See Configuration.
- States:
  - IDLE (reset state).
  - RUN.
  - DONE (one-shot finished; behaves like IDLE but retains `COUNT`=0).
- IDLE/DONE → RUN: write to `CTRL` with `EN`=1. Effects: `COUNT` ← `LOAD`, prescaler ← 0.
- Any state → IDLE: write to `CTRL` with `EN`=0. `COUNT` holds its value and the prescaler clears.
- `CTRL` write with `EN`=1 while already in RUN: only `PERIODIC`/`IRQ_EN` are updated. There is no restart.
- In RUN, the prescaler counts 0..`PRE_LIMIT`. A tick occurs on the cycle where prescaler == `PRE_LIMIT`.
- On a tick with `COUNT` ≠ 0: `COUNT` decrements.
- On a tick with `COUNT` == 0 (expiry):
  - `EXPIRED` ← 1 and `EXP_CNT` increments.
  - If `PERIODIC`: `COUNT` ← `LOAD` and the block stays in RUN.
  - Otherwise: the block goes to DONE and `CTRL.EN` ← 0.
- `LOAD`=0 in periodic mode expires on every tick.
- Writes to `LOAD` take effect at the next start or reload. They never modify `COUNT` directly.

## Timing
- The register write is registered at the `clk` edge where `we`=1. Read data reflects it from the next cycle.
- Start edge is t0. First expiry occurs at edge t0 + (`LOAD`+1)·(`PRE_LIMIT`+1). `EXPIRED` and `irq` are high from that edge.
- Periodic period is (`LOAD`+1)·(`PRE_LIMIT`+1) cycles exactly, with no drift.
- A `STATUS` write-1 and an expiry in the same cycle: the set wins and `EXPIRED` stays 1.
- A `COUNT` write and a tick in the same cycle: the write wins and no decrement occurs.
- A `CTRL` `EN`=0 write and an expiry in the same cycle: the write wins, there is no expiry, and `EXPIRED` is unchanged.
- `irq` falls the cycle after the clearing write, or after an `IRQ_EN`=0 write.
- Asserting `rst_n` low mid-count clears all state and `irq` immediately, asynchronously.

## Configuration
- `COUNTDOWN_TIMER_EXPCNT_EN` defined:
  - `EXP_CNT` is a 16-bit counter that saturates at 0xFFFF, zero-extended on read.
  - Any write to 0x10 clears it.
- Macro undefined:
  - The counter logic is absent and 0x10 reads 0.
  - Writes to 0x10 are ignored.

## Structure
- Register offsets (0x00–0x10) and `CTRL`/`STATUS` bit indices go in a shared defines header. Software drivers include the same header.
- State encodings are defined as localparams in the block.
- Sub-module `tick_prescaler`:
  - Inputs: `clk`, `rst_n`, `clr`, `run`. Output: `tick`.
  - Parameter `LIMIT`.
  - Width is `$clog2(LIMIT+1)`, minimum 1. `LIMIT`=0 yields a tick every cycle in run.

## Test plan
- One-shot: `PRE_LIMIT`=3, `LOAD`=4, `CTRL`=0x1 → `EXPIRED`=1 exactly 20 cycles after the start edge; `CTRL` reads 0x0; `COUNT`=0; state DONE.
- Periodic with irq: `PRE_LIMIT`=0, `LOAD`=2, `CTRL`=0x7 → expiries at +3, +6, +9 cycles; `irq` high after the first; W1C on `STATUS` at +4 drops `irq` at +5; `irq` re-rises at +6.
- Simultaneous events:
  - W1C `STATUS` on the expiry cycle → `EXPIRED` stays 1.
  - `COUNT` write of 10 on a tick cycle → the next read is 10.
- Stop and restart: `CTRL`=0 mid-run at `COUNT`=7 → `COUNT` holds 7 for 50 cycles. `CTRL`=0x1 → reloads from `LOAD`.
- Reset mid-run: drive `rst_n` low with `irq`=1 → `irq`, `COUNT`, `CTRL`, `STATUS` all 0 immediately, before any clock edge.
- `EXP_CNT`: `LOAD`=0, periodic, 100 ticks → reads 100 with the macro defined, 0 without. A write to 0x10 clears it.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared register map and bit positions for the countdown timer; software drivers mirror these values.
// CLK_FREQ falls back to 100 MHz when the build does not provide it.
`ifndef CLK_FREQ
`define CLK_FREQ 100000000
`endif

package countdown_timer_pkg;
  localparam logic [7:0] ADDR_LOAD    = 8'h00;
  localparam logic [7:0] ADDR_COUNT   = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
  localparam logic [7:0] ADDR_EXP_CNT = 8'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_EXPIRED = 0;
endpackage

// File: rtl/countdown_timer_if.sv
// Peripheral bus: 8-bit byte address, 32-bit data, single-cycle write strobe, combinational read.
interface countdown_timer_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (output address, output write_data, output we, output re, input read_data);
  modport slave  (input address, input write_data, input we, input re, output read_data);
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk to a one-cycle tick every LIMIT+1 cycles while run is high; clr restarts the phase.
module tick_prescaler #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Programmable one-shot/periodic countdown timer with level irq = EXPIRED & IRQ_EN.
// Define COUNTDOWN_TIMER_EXPCNT_EN to build the saturating 16-bit expiry counter at 0x10.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ  = `CLK_FREQ,
  parameter int TICK_HZ = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_if.slave      bus,
  output logic                  irq
);
  localparam int PRE_LIMIT = CLK_HZ / TICK_HZ - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] load, count, count_nxt;
  logic        periodic, periodic_nxt;
  logic        irq_en, irq_en_nxt;
  logic        expired, expired_nxt;
  logic        tick, pre_clr;
  logic        load_wr, count_wr, ctrl_wr, status_wr, exp_wr;
  logic        start, stop, step, expire;
  logic [31:0] exp_rd;
  logic        unused_re;

  assign unused_re = bus.re;

  tick_prescaler #(.LIMIT(PRE_LIMIT)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .run   (state == ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    load_wr   = bus.we && (bus.address == ADDR_LOAD);
    count_wr  = bus.we && (bus.address == ADDR_COUNT);
    ctrl_wr   = bus.we && (bus.address == ADDR_CTRL);
    status_wr = bus.we && (bus.address == ADDR_STATUS);
    exp_wr    = bus.we && (bus.address == ADDR_EXP_CNT);
    start     = ctrl_wr && bus.write_data[CTRL_EN] && (state != ST_RUN);
    stop      = ctrl_wr && !bus.write_data[CTRL_EN];
    // Software writes to COUNT or a stop take priority over the tick in the same cycle.
    step      = tick && !stop && !count_wr;
    expire    = step && (count == 32'd0);
    pre_clr   = count_wr || start || stop;
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    periodic_nxt = periodic;
    irq_en_nxt   = irq_en;
    expired_nxt  = expired;

    if (ctrl_wr) begin
      periodic_nxt = bus.write_data[CTRL_PERIODIC];
      irq_en_nxt   = bus.write_data[CTRL_IRQ_EN];
    end

    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_RUN;
      count_nxt = load;
    end else if (count_wr) begin
      count_nxt = bus.write_data;
    end else if (expire) begin
      if (periodic) count_nxt = load;
      else          state_nxt = ST_DONE;
    end else if (step) begin
      count_nxt = count - 32'd1;
    end

    if (status_wr && bus.write_data[STATUS_EXPIRED]) expired_nxt = 1'b0;
    if (expire)                                      expired_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      load     <= '0;
      count    <= '0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      periodic <= periodic_nxt;
      irq_en   <= irq_en_nxt;
      expired  <= expired_nxt;
      if (load_wr) load <= bus.write_data;
    end
  end

`ifdef COUNTDOWN_TIMER_EXPCNT_EN
  logic [15:0] exp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cnt <= '0;
    end else if (exp_wr) begin
      exp_cnt <= '0;
    end else if (expire && (exp_cnt != 16'hFFFF)) begin
      exp_cnt <= exp_cnt + 16'd1;
    end
  end

  assign exp_rd = {16'h0000, exp_cnt};
`else
  logic unused_exp_wr;
  assign unused_exp_wr = exp_wr;
  assign exp_rd = '0;
`endif

  assign irq = expired && irq_en;

  always_comb begin
    bus.read_data = '0;
    case (bus.address)
      ADDR_LOAD:    bus.read_data = load;
      ADDR_COUNT:   bus.read_data = count;
      ADDR_CTRL:    bus.read_data = {29'd0, irq_en, periodic, state == ST_RUN};
      ADDR_STATUS:  bus.read_data = {31'd0, expired};
      ADDR_EXP_CNT: bus.read_data = exp_rd;
      default:      bus.read_data = '0;
    endcase
  end
endmodule
